// File: rtl/sfp_framer_pkg.sv
// sfp_framer shared constants: K character, control codes, FSM states.
// ST_CRC exists only when SFP_FRAMER_CRC_EN is defined.
package sfp_framer_pkg;

  localparam logic [7:0] K28_5   = 8'hBC;
  localparam logic [7:0] C_VS1   = 8'h01;
  localparam logic [7:0] C_VS2   = 8'h02;
  localparam logic [7:0] C_SOP1  = 8'h05;
  localparam logic [7:0] C_SOP2  = 8'h06;
  localparam logic [7:0] C_EOP1  = 8'h07;
  localparam logic [7:0] C_EOP2  = 8'h08;
  localparam logic [7:0] C_COMMA = 8'h09;
  localparam logic [7:0] C_STALL = 8'h0A;
  localparam logic [7:0] C_EOPE  = 8'h0B;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_VS1,
    ST_VS2,
    ST_SOP1,
    ST_SOP2,
    ST_DATA,
`ifdef SFP_FRAMER_CRC_EN
    ST_CRC,
`endif
    ST_EOP1,
    ST_EOP2,
    ST_DROP
  } state_t;

endpackage

// File: rtl/sfp_framer_if.sv
// Valid/ready payload stream feeding sfp_framer.
interface sfp_framer_if #(
  parameter int BYTES = 4
);
  logic               s_valid;
  logic               s_ready;
  logic [BYTES*8-1:0] s_data;
  logic               s_last;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready
  );
endinterface

// File: rtl/sfp_crc32_word.sv
// One BYTES-wide step of reflected CRC-32 (poly 04C11DB7), byte0 first.
module sfp_crc32_word #(
  parameter int BYTES = 4
) (
  input  logic [31:0]        i_crc,
  input  logic [BYTES*8-1:0] i_data,
  output logic [31:0]        o_crc
);

  always_comb begin
    logic [31:0] c;
    c = i_crc;
    for (int i = 0; i < BYTES*8; i++) begin
      if (c[0] ^ i_data[i])
        c = (c >> 1) ^ 32'hEDB88320;
      else
        c = c >> 1;
    end
    o_crc = c;
  end

endmodule

// File: rtl/sfp_framer.sv
// GT TX framer: K-coded control words around a valid/ready payload stream.
// Define SFP_FRAMER_CRC_EN to append a CRC-32 word to each normal packet.
module sfp_framer
  import sfp_framer_pkg::*;
#(
  parameter int          BYTES        = 4,
  parameter int          MAX_WORDS    = 1024,
  parameter int          COMMA_PERIOD = 256,
  parameter logic [7:0]  CH_ID        = 8'h01,
  parameter logic [7:0]  PAD_BYTE     = 8'h55,
  parameter logic [31:0] IDLE_WORD    = 32'ha151a252
) (
  input  logic               tx_clk,
  input  logic               tx_rst_n,
  input  logic               vs_pulse,
  sfp_framer_if.slave        s,
  output logic [BYTES*8-1:0] gt_txdata,
  output logic [BYTES-1:0]   gt_txcharisk,
  output logic [15:0]        pkt_cnt,
  output logic               trunc_err,
  output logic               busy
);

  localparam int W   = BYTES*8;
  localparam int WCW = $clog2(MAX_WORDS+1);
  localparam int ICW = $clog2(COMMA_PERIOD);
  localparam logic [BYTES-1:0] K_CTL = BYTES'(1);

  state_t           r_state, w_nxt;
  logic [ICW-1:0]   r_idle_cnt;
  logic [WCW-1:0]   r_wcnt;
  logic             r_drop;
  logic             r_vs_pend;
  logic [W-1:0]     w_tx;
  logic [BYTES-1:0] w_k;
  logic             w_trunc;
  logic             w_acc;
  logic             w_vs;
  logic             w_comma;
  logic             w_full;

  function automatic logic [W-1:0] ctrl(
    input logic [7:0] code
  );
    logic [W-1:0] v;
    v         = {BYTES{PAD_BYTE}};
    v[7:0]    = K28_5;
    v[15:8]   = code;
    v[23:16]  = CH_ID;
    return v;
  endfunction

  assign s.s_ready = (r_state == ST_DATA) ||
                     (r_state == ST_DROP);
  assign busy      = (r_state != ST_IDLE);
  assign w_acc     = s.s_valid & s.s_ready;
  assign w_vs      = r_vs_pend | vs_pulse;
  assign w_comma   = (r_idle_cnt == ICW'(COMMA_PERIOD-1));
  assign w_full    = (r_wcnt == WCW'(MAX_WORDS-1));

`ifdef SFP_FRAMER_CRC_EN
  logic [31:0] r_crc, w_crc_nxt;

  sfp_crc32_word #(.BYTES(BYTES)) u_crc (
    .i_crc  (r_crc),
    .i_data (s.s_data),
    .o_crc  (w_crc_nxt)
  );

  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n)
      r_crc <= '1;
    else if (r_state == ST_SOP1)
      r_crc <= '1;
    else if (r_state == ST_DATA && w_acc)
      r_crc <= w_crc_nxt;
  end
`endif

  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n) r_state <= ST_IDLE;
    else           r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      ST_IDLE:
        if (w_vs)           w_nxt = ST_VS1;
        else if (s.s_valid) w_nxt = ST_SOP1;
      ST_VS1:  w_nxt = ST_VS2;
      ST_VS2:  w_nxt = ST_IDLE;
      ST_SOP1: w_nxt = ST_SOP2;
      ST_SOP2: w_nxt = ST_DATA;
      ST_DATA:
        if (w_acc && s.s_last)
`ifdef SFP_FRAMER_CRC_EN
          w_nxt = ST_CRC;
`else
          w_nxt = ST_EOP1;
`endif
        else if (w_acc && w_full)
          w_nxt = ST_EOP1;
`ifdef SFP_FRAMER_CRC_EN
      ST_CRC:  w_nxt = ST_EOP1;
`endif
      ST_EOP1: w_nxt = ST_EOP2;
      ST_EOP2: w_nxt = r_drop ? ST_DROP : ST_IDLE;
      ST_DROP:
        if (w_acc && s.s_last) w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_tx    = {(BYTES/4){IDLE_WORD}};
    w_k     = '0;
    w_trunc = 1'b0;
    unique case (r_state)
      ST_IDLE:
        if (w_comma) begin
          w_tx = ctrl(C_COMMA);
          w_k  = K_CTL;
        end
      ST_VS1:  begin w_tx = ctrl(C_VS1);  w_k = K_CTL; end
      ST_VS2:  begin w_tx = ctrl(C_VS2);  w_k = K_CTL; end
      ST_SOP1: begin w_tx = ctrl(C_SOP1); w_k = K_CTL; end
      ST_SOP2: begin w_tx = ctrl(C_SOP2); w_k = K_CTL; end
      ST_DATA:
        if (w_acc) begin
          w_tx = s.s_data;
        end else begin
          w_tx = ctrl(C_STALL);
          w_k  = K_CTL;
        end
`ifdef SFP_FRAMER_CRC_EN
      ST_CRC:  w_tx = W'(~r_crc);
`endif
      ST_EOP1: begin
        w_tx    = ctrl(r_drop ? C_EOPE : C_EOP1);
        w_k     = K_CTL;
        w_trunc = r_drop;
      end
      ST_EOP2: begin w_tx = ctrl(C_EOP2); w_k = K_CTL; end
      default: ;
    endcase
  end

  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      gt_txdata    <= '0;
      gt_txcharisk <= '0;
      trunc_err    <= 1'b0;
      pkt_cnt      <= '0;
      r_idle_cnt   <= '0;
      r_wcnt       <= '0;
      r_drop       <= 1'b0;
      r_vs_pend    <= 1'b0;
    end else begin
      gt_txdata    <= w_tx;
      gt_txcharisk <= w_k;
      trunc_err    <= w_trunc;
      if (r_state == ST_EOP2)
        pkt_cnt <= pkt_cnt + 16'd1;
      if (r_state == ST_IDLE && w_nxt == ST_IDLE)
        r_idle_cnt <= w_comma ? '0 : r_idle_cnt + 1'b1;
      else
        r_idle_cnt <= '0;
      if (r_state != ST_DATA)
        r_wcnt <= '0;
      else if (w_acc)
        r_wcnt <= r_wcnt + 1'b1;
      // truncation: the word that fills the packet was not the last one
      if (r_state == ST_DATA && w_acc && !s.s_last && w_full)
        r_drop <= 1'b1;
      else if (r_state == ST_DROP && w_acc && s.s_last)
        r_drop <= 1'b0;
      if (r_state == ST_IDLE && w_nxt == ST_VS1)
        r_vs_pend <= 1'b0;
      else if (vs_pulse)
        r_vs_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sfp_framer.sv
// Self-checking bench for sfp_framer (BYTES=4, MAX_WORDS=4, COMMA_PERIOD=8).
module tb_sfp_framer;

  localparam int          BYTES  = 4;
  localparam int          MAXW   = 4;
  localparam int          CP     = 8;
  localparam logic [31:0] IDLE_W = 32'ha151a252;

  typedef logic [36:0] ev_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        vs    = 1'b0;
  logic [31:0] txd;
  logic [3:0]  txk;
  logic [15:0] pcnt;
  logic        trunc;
  logic        busy;

  sfp_framer_if #(.BYTES(BYTES)) ifc ();

  sfp_framer #(
    .BYTES        (BYTES),
    .MAX_WORDS    (MAXW),
    .COMMA_PERIOD (CP)
  ) dut (
    .tx_clk       (clk),
    .tx_rst_n     (rst_n),
    .vs_pulse     (vs),
    .s            (ifc.slave),
    .gt_txdata    (txd),
    .gt_txcharisk (txk),
    .pkt_cnt      (pcnt),
    .trunc_err    (trunc),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  ev_t         ev_q[$];
  ev_t         exp_q[$];
  logic        rec     = 1'b0;
  int          n_trunc = 0;
  int          n_chk   = 0;
  int          n_pass  = 0;
  int          n_pkts  = 0;
  logic [31:0] crc_acc;

  function automatic ev_t ctl(input logic [7:0] code, input logic tr);
    return {tr, 4'b0001, 8'h55, 8'h01, code, 8'hBC};
  endfunction

  function automatic ev_t dat(input logic [31:0] d);
    return {1'b0, 4'b0000, d};
  endfunction

  function automatic logic [31:0] crc_word(input logic [31:0] c,
                                           input logic [31:0] d);
    for (int b = 0; b < 4; b++) begin
      c = c ^ {24'h0, d[8*b +: 8]};
      for (int k = 0; k < 8; k++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // Non-idle, non-comma output words form the transaction-level event stream
  always @(negedge clk) begin
    if (rec) begin
      if (trunc) n_trunc++;
      if (!((txk == 4'b0 && txd == IDLE_W) ||
            ({1'b0, txk, txd} == ctl(8'h09, 1'b0))))
        ev_q.push_back({trunc, txk, txd});
    end
  end

  task automatic chk(input string tag, input logic [63:0] o,
                     input logic [63:0] e);
    n_chk++;
    assert (o === e) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, o, e);
  endtask

  task automatic cmp_events(input string tag);
    chk({tag, " count"}, 64'(ev_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      ev_t o;
      o = (i < ev_q.size()) ? ev_q[i] : 'x;
      chk(tag, o, exp_q[i]);
    end
    ev_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] d;
    do d = $urandom; while (d == IDLE_W);
    return d;
  endfunction

  task automatic push(input logic [31:0] d, input logic last,
                      input bit lat);
    int n;
    ifc.s_valid = 1'b1;
    ifc.s_data  = d;
    ifc.s_last  = last;
    n = 0;
    while (ifc.s_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("push timeout", 64'(ifc.s_ready), 64'd1);
    @(negedge clk);
    ifc.s_valid = 1'b0;
    ifc.s_last  = 1'b0;
    if (lat) chk("latency", {txk, txd}, {4'b0, d});
  endtask

  task automatic send_pkt(input int n, input int gmin, input int gmax);
    logic [31:0] d;
    int g;
    exp_q.push_back(ctl(8'h05, 1'b0));
    exp_q.push_back(ctl(8'h06, 1'b0));
    crc_acc = '1;
    for (int i = 0; i < n; i++) begin
      if (i > 0 && i < MAXW) begin
        g = $urandom_range(gmax, gmin);
        repeat (g) begin
          @(negedge clk);
          exp_q.push_back(ctl(8'h0A, 1'b0));
        end
      end
      d = rand_word();
      push(d, i == n-1, i < MAXW);
      if (i < MAXW) begin
        exp_q.push_back(dat(d));
        crc_acc = crc_word(crc_acc, d);
      end
      if (i == MAXW-1 && n > MAXW) begin
        exp_q.push_back(ctl(8'h0B, 1'b1));
        exp_q.push_back(ctl(8'h08, 1'b0));
      end
    end
    if (n <= MAXW) begin
`ifdef SFP_FRAMER_CRC_EN
      exp_q.push_back(dat(~crc_acc));
`endif
      exp_q.push_back(ctl(8'h07, 1'b0));
      exp_q.push_back(ctl(8'h08, 1'b0));
    end
    n_pkts++;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    ifc.s_valid = 1'b0;
    ifc.s_last  = 1'b0;
    ifc.s_data  = '0;

    repeat (3) @(negedge clk);
    chk("rst txdata", 64'(txd), 64'd0);
    chk("rst charisk", 64'(txk), 64'd0);
    chk("rst pkt_cnt", 64'(pcnt), 64'd0);
    chk("rst trunc", 64'(trunc), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst s_ready", 64'(ifc.s_ready), 64'd0);

    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k % CP == 0)
        chk("idle comma", {1'b0, txk, txd}, ctl(8'h09, 1'b0));
      else
        chk("idle word", {1'b0, txk, txd}, dat(IDLE_W));
    end

    vs = 1'b1;
    @(negedge clk);
    vs = 1'b0;
    chk("vs busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("vs1", {1'b0, txk, txd}, ctl(8'h01, 1'b0));
    @(negedge clk);
    chk("vs2", {1'b0, txk, txd}, ctl(8'h02, 1'b0));
    @(negedge clk);
    chk("vs idle", {1'b0, txk, txd}, dat(IDLE_W));

    rec = 1'b1;
    send_pkt(3, 0, 0);
    cmp_events("pkt3");
    chk("pkt_cnt 3w", 64'(pcnt), 64'(n_pkts));

    send_pkt(2, 2, 2);
    cmp_events("stall2");
    send_pkt(4, 1, 2);
    cmp_events("maxw last");
    chk("pkt_cnt maxw", 64'(pcnt), 64'(n_pkts));

    for (int r = 0; r < 6; r++) begin
      send_pkt($urandom_range(4, 1), 0, 2);
      cmp_events("rand pkt");
    end
    chk("pkt_cnt rand", 64'(pcnt), 64'(n_pkts));

    send_pkt(6, 0, 1);
    cmp_events("trunc");
    chk("trunc pulses", 64'(n_trunc), 64'd1);
    chk("pkt_cnt trunc", 64'(pcnt), 64'(n_pkts));

    send_pkt(2, 0, 1);
    cmp_events("after drop");

    a = rand_word();
    b = rand_word();
    exp_q.push_back(ctl(8'h05, 1'b0));
    exp_q.push_back(ctl(8'h06, 1'b0));
    push(a, 1'b0, 1'b1);
    vs = 1'b1;
    @(negedge clk);
    vs = 1'b0;
    push(b, 1'b1, 1'b1);
    exp_q.push_back(dat(a));
    exp_q.push_back(ctl(8'h0A, 1'b0));
    exp_q.push_back(dat(b));
`ifdef SFP_FRAMER_CRC_EN
    exp_q.push_back(dat(~crc_word(crc_word('1, a), b)));
`endif
    exp_q.push_back(ctl(8'h07, 1'b0));
    exp_q.push_back(ctl(8'h08, 1'b0));
    exp_q.push_back(ctl(8'h01, 1'b0));
    exp_q.push_back(ctl(8'h02, 1'b0));
    n_pkts++;
    repeat (10) @(negedge clk);
    cmp_events("vs in data");
    chk("pkt_cnt vs", 64'(pcnt), 64'(n_pkts));

    rec = 1'b0;
    push(rand_word(), 1'b0, 1'b1);
    chk("mid busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst txdata", 64'(txd), 64'd0);
    chk("mid rst s_ready", 64'(ifc.s_ready), 64'd0);
    chk("mid rst busy", 64'(busy), 64'd0);
    chk("mid rst pkt_cnt", 64'(pcnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post rst idle", {1'b0, txk, txd}, dat(IDLE_W));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
